// File: rtl/waveform_gen_if.sv
// Stream/config bundle for waveform_gen: sample request, programmable shape
// controls, and the registered sample/valid/wrap outputs.
interface waveform_gen_if #(
  parameter int N_FRAC    = 7,
  parameter int DIV_WIDTH = 4
);
  localparam int W = N_FRAC + 1;

  logic [1:0]           mode_i;
  logic signed [W-1:0]  amplitude_i;
  logic signed [W-1:0]  addend_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic                 next_data_strobe_i;
  logic signed [W-1:0]  data_o;
  logic                 data_out_valid_strobe_o;
  logic                 wrap_strobe_o;

  modport master (
    output mode_i, amplitude_i, addend_i, div_i, next_data_strobe_i,
    input  data_o, data_out_valid_strobe_o, wrap_strobe_o
  );

  modport slave (
    input  mode_i, amplitude_i, addend_i, div_i, next_data_strobe_i,
    output data_o, data_out_valid_strobe_o, wrap_strobe_o
  );
endinterface

// File: rtl/waveform_gen.sv
// Strobe-driven signed test-waveform generator (saw/tri/square/DC) with
// programmable amplitude, phase step and rate division; feeds the CORDIC core.
module waveform_gen #(
  parameter int N_FRAC    = 7,
  parameter int DIV_WIDTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  waveform_gen_if.slave  bus
);
  localparam int W = N_FRAC + 1;

  // mode | meaning
  // SAW  | ramp up, wrap to -amp past +amp
  // TRI  | ramp up/down between +-amp, wrap marker at the bottom turn
  // SQR  | saw phase, output sign-sliced to +-amp
  // DC   | phase frozen, output +amp
  localparam logic [1:0] MODE_SAW = 2'b00;
  localparam logic [1:0] MODE_TRI = 2'b01;
  localparam logic [1:0] MODE_SQR = 2'b10;
  localparam logic [1:0] MODE_DC  = 2'b11;

  logic signed [W-1:0]  phase;
  logic                 dir;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [1:0]           mode_q;

  logic signed [W:0]    amp_eff, neg_amp, step, sum, diff, nxt_phase;
  logic                 nxt_dir, nxt_wrap, step_pos;
  logic signed [W-1:0]  nxt_data;

  // One extra bit of headroom so phase+-step can never sign-wrap.
  always_comb begin
    amp_eff   = bus.amplitude_i[W-1] ? '0 : {1'b0, bus.amplitude_i};
    neg_amp   = -amp_eff;
    step      = {bus.addend_i[W-1], bus.addend_i};
    step_pos  = !step[W] && (step != '0);
    sum       = {phase[W-1], phase} + step;
    diff      = {phase[W-1], phase} - step;
    nxt_phase = {phase[W-1], phase};
    nxt_dir   = dir;
    nxt_wrap  = 1'b0;

    if (step_pos) begin
      case (mode_q)
        MODE_SAW, MODE_SQR: begin
          if (sum > amp_eff) begin
            nxt_phase = neg_amp;
            nxt_wrap  = 1'b1;
          end else begin
            nxt_phase = sum;
          end
        end
        MODE_TRI: begin
          if (!dir) begin
            if (sum >= amp_eff) begin
              nxt_phase = amp_eff;
              nxt_dir   = 1'b1;
            end else begin
              nxt_phase = sum;
            end
          end else begin
            if (diff <= neg_amp) begin
              nxt_phase = neg_amp;
              nxt_dir   = 1'b0;
              nxt_wrap  = 1'b1;
            end else begin
              nxt_phase = diff;
            end
          end
        end
        default: ;
      endcase
    end

    case (mode_q)
      MODE_SQR: nxt_data = nxt_phase[W] ? neg_amp[W-1:0] : amp_eff[W-1:0];
      MODE_DC:  nxt_data = amp_eff[W-1:0];
      default:  nxt_data = nxt_phase[W-1:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase                       <= '0;
      dir                         <= 1'b0;
      div_cnt                     <= '0;
      mode_q                      <= bus.mode_i;
      bus.data_o                  <= '0;
      bus.data_out_valid_strobe_o <= 1'b0;
      bus.wrap_strobe_o           <= 1'b0;
    end else if (bus.mode_i != mode_q) begin
      // Mode switch restarts the waveform; a coincident strobe still gets a
      // (zero) sample so the consumer's request count stays in step.
      mode_q                      <= bus.mode_i;
      phase                       <= '0;
      dir                         <= 1'b0;
      div_cnt                     <= '0;
      bus.data_o                  <= '0;
      bus.data_out_valid_strobe_o <= bus.next_data_strobe_i;
      bus.wrap_strobe_o           <= 1'b0;
    end else if (bus.next_data_strobe_i) begin
      bus.data_out_valid_strobe_o <= 1'b1;
      // >= so that lowering div_i below the running count restarts at once.
      if (div_cnt >= bus.div_i) begin
        div_cnt           <= '0;
        phase             <= nxt_phase[W-1:0];
        dir               <= nxt_dir;
        bus.data_o        <= nxt_data;
        bus.wrap_strobe_o <= nxt_wrap;
      end else begin
        div_cnt           <= div_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        bus.wrap_strobe_o <= 1'b0;
      end
    end else begin
      bus.data_out_valid_strobe_o <= 1'b0;
      bus.wrap_strobe_o           <= 1'b0;
    end
  end
endmodule

// File: tb/tb_waveform_gen.sv
// Directed scoreboard bench for waveform_gen: stimulus pushes expected samples,
// a negedge monitor pops and checks them against every valid pulse.
module tb_waveform_gen;
  logic clk_i = 1'b0;
  logic rst_i;

  waveform_gen_if #(.N_FRAC(7), .DIV_WIDTH(4)) bus ();

  waveform_gen #(.N_FRAC(7), .DIV_WIDTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic signed [7:0] data;
    logic              wrap;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   idx   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && bus.wrap_strobe_o && !bus.data_out_valid_strobe_o) begin
      n_cmp++; n_bad++;
      $display("FAIL wrap_without_valid cyc=%0d", cyc);
    end
    if (bus.data_out_valid_strobe_o) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid cyc=%0d data=%0d", cyc, bus.data_o);
      end else begin
        e = q.pop_front();
        idx++;
        if (bus.data_o !== e.data || bus.wrap_strobe_o !== e.wrap || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL sample#%0d got data=%0d wrap=%0b cyc=%0d, want data=%0d wrap=%0b cyc=%0d",
                   idx, bus.data_o, bus.wrap_strobe_o, cyc, e.data, e.wrap, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int want);
    n_cmp++;
    if (actual != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, actual, want);
    end
  endtask

  task automatic strobe(input int d, input bit w);
    exp_t e;
    e.data = 8'(d);
    e.wrap = w;
    e.cyc  = cyc + 1;
    q.push_back(e);
    bus.next_data_strobe_i = 1'b1;
    @(posedge clk_i);
    #1 bus.next_data_strobe_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input int amp, input int add, input int dv);
    bus.amplitude_i = 8'(amp);
    bus.addend_i    = 8'(add);
    bus.div_i       = 4'(dv);
  endtask

  initial begin
    rst_i = 1'b1;
    bus.mode_i = 2'b00;
    bus.next_data_strobe_i = 1'b0;
    cfg(5, 2, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("reset_data",  int'(bus.data_o), 0);
    check("reset_valid", int'(bus.data_out_valid_strobe_o), 0);
    check("reset_wrap",  int'(bus.wrap_strobe_o), 0);

    // SAW amp=5 add=2
    strobe(2, 0); strobe(4, 0); strobe(-5, 1); strobe(-3, 0);
    idle(2);
    check("saw_hold", int'(bus.data_o), -3);
    strobe(-1, 0); strobe(1, 0); strobe(3, 0); strobe(5, 0); strobe(-5, 1);

    // switch to TRI on a strobe cycle
    cfg(3, 2, 0);
    bus.mode_i = 2'b01;
    strobe(0, 0);
    strobe(2, 0); strobe(3, 0); strobe(1, 0); strobe(-1, 0);
    idle(1);
    check("tri_hold", int'(bus.data_o), -1);
    strobe(-3, 1); strobe(-1, 0); strobe(1, 0); strobe(3, 0);
    strobe(1, 0);

    // reset coincident with a strobe
    rst_i = 1'b1;
    bus.next_data_strobe_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0; bus.next_data_strobe_i = 1'b0;
    check("rst_mid_data",  int'(bus.data_o), 0);
    check("rst_mid_valid", int'(bus.data_out_valid_strobe_o), 0);
    check("rst_mid_wrap",  int'(bus.wrap_strobe_o), 0);
    strobe(2, 0); strobe(3, 0);

    // SQUARE amp=100 add=64, mode change without strobe
    bus.mode_i = 2'b10;
    idle(1);
    check("sqr_modechg_data", int'(bus.data_o), 0);
    cfg(100, 64, 0);
    strobe(100, 0); strobe(-100, 1); strobe(-100, 0);
    strobe(100, 0); strobe(100, 0); strobe(-100, 1);

    // SAW overflow edge, then rate divider
    bus.mode_i = 2'b00;
    idle(1);
    cfg(127, 127, 0);
    strobe(127, 0); strobe(-127, 1); strobe(0, 0); strobe(127, 0); strobe(-127, 1);
    bus.div_i = 4'd2;
    strobe(-127, 0); strobe(-127, 0); strobe(0, 0);
    strobe(0, 0); strobe(0, 0); strobe(127, 0);
    bus.div_i = 4'd3;
    strobe(127, 0); strobe(127, 0);
    bus.div_i = 4'd1;
    strobe(-127, 1);

    // DC, including negative amplitude clamped to zero
    bus.mode_i = 2'b11;
    idle(1);
    cfg(50, 1, 0);
    strobe(50, 0);
    bus.amplitude_i = -8'sd5;
    strobe(0, 0);

    // SAW with amp_eff=0 wraps every advance; non-positive step holds
    bus.mode_i = 2'b00;
    idle(1);
    cfg(0, 3, 0);
    strobe(0, 1); strobe(0, 1);
    cfg(5, -1, 0);
    strobe(0, 0);
    bus.addend_i = 8'sd0;
    strobe(0, 0);
    bus.addend_i = 8'sd2;
    strobe(2, 0);

    idle(3);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
